mem_access_sched: RTL and testbench

MEM_ACCESS_SCHED -- requirements
Module: mem_access_sched

---
 rtl/mem_access_sched_pkg.sv | 22 ++
 rtl/mem_access_sched_if.sv | 29 ++
 rtl/mem_access_sched_wait_timer.sv | 40 ++++
 rtl/mem_access_sched.sv | 92 +++++++++
 tb/tb_mem_access_sched.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_sched_pkg.sv
// Shared cache-controller constants: scheduler state encodings and default
// line geometry / memory timing.
package mem_access_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WB   = 2'b01,
    ST_FILL = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam int DEF_WORDS = 4;
  localparam int DEF_WBITS = 2;
  localparam int DEF_WAIT  = 2;
  localparam int DEF_CBITS = 1;

  // Word transfers happen only while a write-back or a fill owns the bus.
  function automatic logic is_xfer(state_e s);
    return (s == ST_WB) || (s == ST_FILL);
  endfunction

endpackage

// File: rtl/mem_access_sched_if.sv
// Request/acknowledge and memory-bus strobes between the cache controller
// and the memory access scheduler.
interface mem_access_sched_if #(
  parameter int WBITS = mem_access_sched_pkg::DEF_WBITS
);

  logic             wb_req;
  logic             fill_req;
  logic             wb_ack;
  logic             fill_ack;
  logic             mem_wr;
  logic             mem_rd;
  logic [WBITS-1:0] word_idx;
  logic             word_stb;
  logic             busy;

  // Requester side (cache controller).
  modport master (
    output wb_req, fill_req,
    input  wb_ack, fill_ack, mem_wr, mem_rd, word_idx, word_stb, busy
  );

  // Scheduler side.
  modport slave (
    input  wb_req, fill_req,
    output wb_ack, fill_ack, mem_wr, mem_rd, word_idx, word_stb, busy
  );

endinterface

// File: rtl/mem_access_sched_wait_timer.sv
// Mod-WAIT wait-state counter; terminal count marks the cycle a memory word
// completes.
module mem_access_sched_wait_timer #(
  parameter int WAIT  = mem_access_sched_pkg::DEF_WAIT,
  parameter int CBITS = mem_access_sched_pkg::DEF_CBITS
) (
  input  logic clk,
  input  logic r,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [CBITS-1:0] LAST = CBITS'(WAIT - 1);

  logic [CBITS-1:0] cnt_q;
  logic [CBITS-1:0] cnt_d;

  assign tc = en && (cnt_q == LAST);

  // NOTE: next-state default assigned first so no path leaves cnt_d unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CBITS'(1);
    end
  end

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_sched.sv
// Memory access scheduler: arbitrates write-back over line fill, then
// sequences WORDS word transfers of WAIT cycles each before a one-cycle ack.
module mem_access_sched
  import mem_access_sched_pkg::*;
#(
  parameter int WORDS = DEF_WORDS,
  parameter int WBITS = DEF_WBITS,
  parameter int WAIT  = DEF_WAIT,
  parameter int CBITS = DEF_CBITS
) (
  input  logic               clk,
  input  logic               r,
  mem_access_sched_if.slave  bus
);

  localparam logic [WBITS-1:0] LAST_WORD = WBITS'(WORDS - 1);

  state_e           state_q;
  state_e           state_d;
  logic             gsel_q;   // 1: current grant is a write-back
  logic             gsel_d;
  logic [WBITS-1:0] idx_q;
  logic [WBITS-1:0] idx_d;
  logic             xfer;
  logic             stb;

  assign xfer = is_xfer(state_q);

  // Held clear outside transfers, so each access starts at count 0.
  mem_access_sched_wait_timer #(
    .WAIT  (WAIT),
    .CBITS (CBITS)
  ) u_wait_timer (
    .clk (clk),
    .r   (r),
    .en  (xfer),
    .clr (!xfer),
    .tc  (stb)
  );

  always_comb begin
    state_d = state_q;
    gsel_d  = gsel_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        // Dirty line goes out before its replacement comes in.
        if (bus.wb_req) begin
          state_d = ST_WB;
          gsel_d  = 1'b1;
        end else if (bus.fill_req) begin
          state_d = ST_FILL;
          gsel_d  = 1'b0;
        end
      end
      ST_WB, ST_FILL: begin
        if (stb) begin
          if (idx_q == LAST_WORD) begin
            idx_d   = '0;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + WBITS'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q <= ST_IDLE;
      gsel_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      gsel_q  <= gsel_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.mem_wr   = (state_q == ST_WB);
  assign bus.mem_rd   = (state_q == ST_FILL);
  assign bus.word_stb = stb;
  assign bus.word_idx = xfer ? idx_q : '0;
  assign bus.wb_ack   = (state_q == ST_DONE) &&  gsel_q;
  assign bus.fill_ack = (state_q == ST_DONE) && !gsel_q;

endmodule

// File: tb/tb_mem_access_sched.sv
// Bench for mem_access_sched: a default (WAIT=2) and a WAIT=1 instance driven
// by directed then random requesters, checked against a transaction-level model.
module tb_mem_access_sched;

  localparam int WORDS = 4;
  localparam int NCYC  = 2100;

  typedef struct packed {
    logic       busy;
    logic       mem_wr;
    logic       mem_rd;
    logic       word_stb;
    logic [1:0] word_idx;
    logic       wb_ack;
    logic       fill_ack;
  } outs_t;

  logic clk = 1'b0;
  logic r;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_access_sched_if #(.WBITS(2)) ifa ();
  mem_access_sched_if #(.WBITS(2)) ifb ();

  mem_access_sched #(.WORDS(4), .WBITS(2), .WAIT(2), .CBITS(1)) dut_a (
    .clk (clk), .r (r), .bus (ifa)
  );
  mem_access_sched #(.WORDS(4), .WBITS(2), .WAIT(1), .CBITS(1)) dut_b (
    .clk (clk), .r (r), .bus (ifb)
  );

  a_excl_a: assert property (@(posedge clk) !(ifa.mem_rd && ifa.mem_wr))
    else $error("FAIL excl_a: mem_rd and mem_wr both high");
  a_excl_b: assert property (@(posedge clk) !(ifb.mem_rd && ifb.mem_wr))
    else $error("FAIL excl_b: mem_rd and mem_wr both high");

  // Cycle n spans posedge (5+10n) to the next posedge.
  function automatic int cyc_now();
    return int'(($time + 5) / 10) - 1;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc_now(), act, exp);
    end
  endtask

  // Outputs of an access k cycles after its grant: WORDS*wt transfer cycles, then ack.
  function automatic outs_t model_out(bit busy, bit kind, int k, int wt);
    outs_t o;
    o = '0;
    if (busy) begin
      o.busy = 1'b1;
      if (k < WORDS * wt) begin
        o.mem_wr   = kind;
        o.mem_rd   = !kind;
        o.word_idx = 2'(k / wt);
        o.word_stb = ((k % wt) == (wt - 1));
      end else begin
        o.wb_ack   = kind;
        o.fill_ack = !kind;
      end
    end
    return o;
  endfunction

  // ---------------- compare process ----------------
  bit    m_busy [2];
  bit    m_kind [2];
  int    m_k    [2];
  outs_t act    [2];
  bit    wbr    [2];
  bit    flr    [2];

  always @(negedge clk or posedge r) begin
    int    cyc;
    int    wt;
    outs_t exp_o;
    outs_t a;
    outs_t b;
    #1;
    cyc    = cyc_now();
    act[0] = {ifa.busy, ifa.mem_wr, ifa.mem_rd, ifa.word_stb, ifa.word_idx, ifa.wb_ack, ifa.fill_ack};
    act[1] = {ifb.busy, ifb.mem_wr, ifb.mem_rd, ifb.word_stb, ifb.word_idx, ifb.wb_ack, ifb.fill_ack};
    wbr[0] = ifa.wb_req;  flr[0] = ifa.fill_req;
    wbr[1] = ifb.wb_req;  flr[1] = ifb.fill_req;
    a = act[0];
    b = act[1];
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("reset_zero%0d", i), act[i], 8'h00);
        m_busy[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        wt    = (i == 0) ? 2 : 1;
        exp_o = model_out(m_busy[i], m_kind[i], m_k[i], wt);
        check($sformatf("outs%0d", i), act[i], exp_o);
        check($sformatf("excl%0d", i), {7'd0, act[i].mem_rd & act[i].mem_wr}, 8'd0);
        if (!m_busy[i]) begin
          if (wbr[i]) begin
            m_busy[i] = 1'b1; m_kind[i] = 1'b1; m_k[i] = 0;
          end else if (flr[i]) begin
            m_busy[i] = 1'b1; m_kind[i] = 1'b0; m_k[i] = 0;
          end
        end else if (m_k[i] == WORDS * wt) begin
          m_busy[i] = 1'b0;
        end else begin
          m_k[i]++;
        end
      end
      // Hand-computed timelines for the directed phase.
      case (cyc)
        3:  check("a_idle_t0", a.busy, 0);
        4:  check("a_rd_first", {a.mem_rd, a.word_stb}, 2'b10);
        5:  check("a_word0", {a.word_stb, a.word_idx}, 3'b100);
        7:  check("a_word1", {a.word_stb, a.word_idx}, 3'b101);
        8:  check("b_wack", {b.wb_ack, b.word_stb, b.mem_wr}, 3'b100);
        9:  check("a_word2", {a.word_stb, a.word_idx}, 3'b110);
        11: check("a_word3", {a.mem_rd, a.word_stb, a.word_idx}, 4'b1111);
        12: check("a_fack", {a.fill_ack, a.mem_rd}, 2'b10);
        13: check("a_fack_once", {a.busy, a.fill_ack}, 2'b00);
        21: check("a_wb_first", {a.mem_wr, a.mem_rd}, 2'b10);
        29: check("a_wack", {a.wb_ack, a.fill_ack}, 2'b10);
        30: check("a_gap_idle", a.busy, 0);
        31: check("a_fill_after_wb", {a.mem_rd, a.mem_wr}, 2'b10);
        39: check("a_fack2", a.fill_ack, 1);
        50: check("a_post_reset_idle", a.busy, 0);
        51: check("a_regrant", {a.mem_rd, a.word_idx}, 3'b100);
        54: check("a_no_abort_ack", {a.fill_ack, a.mem_rd}, 2'b01);
        59: check("a_fack_regrant", a.fill_ack, 1);
        79: check("a_fack4", a.fill_ack, 1);
        80: check("a_rerequest_idle", {a.busy, a.fill_ack}, 2'b00);
        81: check("a_second_fill", a.mem_rd, 1);
        89: check("a_second_fack", a.fill_ack, 1);
        default: ;
      endcase
      if (cyc >= 4 && cyc <= 7)
        check("b_wait1_word", {b.word_stb, b.word_idx}, {1'b1, 2'(cyc - 4)});
    end
  end

  // ---------------- requesters ----------------
  // A held request drops after its ack unless the requester re-requests.
  function automatic logic next_req(logic req, logic ack, bit raise, bit keep);
    if (req && ack) return keep;
    if (!req)       return raise;
    return req;
  endfunction

  initial begin
    int   n;
    logic ack_p [4];
    bit   rnd;
    r = 1'b1;
    ifa.wb_req = 1'b0; ifa.fill_req = 1'b0;
    ifb.wb_req = 1'b0; ifb.fill_req = 1'b0;
    for (int i = 0; i < 4; i++) ack_p[i] = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    r = 1'b0;
    n = cyc_now();
    while (n < NCYC) begin
      @(posedge clk); #1;
      n   = cyc_now();
      rnd = (n >= 100);
      if (n == 50 || (rnd && $urandom_range(0, 149) == 0)) begin
        r = 1'b1;
        #2;
        r = 1'b0;
      end
      ifa.wb_req   = next_req(ifa.wb_req, ack_p[0],
                              rnd ? ($urandom_range(0, 3) == 0) : (n == 20),
                              rnd ? ($urandom_range(0, 7) == 0) : 1'b0);
      ifa.fill_req = next_req(ifa.fill_req, ack_p[1],
                              rnd ? ($urandom_range(0, 3) == 0) : (n == 3 || n == 20 || n == 45 || n == 70),
                              rnd ? ($urandom_range(0, 7) == 0) : (n == 80));
      ifb.wb_req   = next_req(ifb.wb_req, ack_p[2],
                              rnd ? ($urandom_range(0, 3) == 0) : (n == 3),
                              rnd ? ($urandom_range(0, 7) == 0) : 1'b0);
      ifb.fill_req = next_req(ifb.fill_req, ack_p[3],
                              rnd ? ($urandom_range(0, 3) == 0) : 1'b0,
                              rnd ? ($urandom_range(0, 7) == 0) : 1'b0);
      @(negedge clk); #2;
      ack_p[0] = ifa.wb_ack;
      ack_p[1] = ifa.fill_ack;
      ack_p[2] = ifb.wb_ack;
      ack_p[3] = ifb.fill_ack;
    end
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
